// File: rtl/regfile_ext_slave_if.sv
// ============================================================================
// regfile_ext_slave_if : request/ack register bus plus external-section port
// Revision: 1.0
// ============================================================================
`default_nettype none

interface regfile_ext_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic                  reg_req;
  logic                  reg_we;
  logic [ADDR_W-1:0]     reg_addr;
  logic [DATA_W-1:0]     reg_wdata;
  logic [DATA_W/8-1:0]   reg_be;
  logic                  reg_ack;
  logic [DATA_W-1:0]     reg_rdata;
  logic                  reg_err;

  logic                  ext_req;
  logic                  ext_we;
  logic [ADDR_W-1:0]     ext_addr;
  logic [DATA_W-1:0]     ext_wdata;
  logic [DATA_W/8-1:0]   ext_be;
  logic                  ext_ack;
  logic [DATA_W-1:0]     ext_rdata;

  modport slave (
    input  reg_req, reg_we, reg_addr, reg_wdata, reg_be, ext_ack, ext_rdata,
    output reg_ack, reg_rdata, reg_err, ext_req, ext_we, ext_addr, ext_wdata, ext_be
  );

  modport master (
    output reg_req, reg_we, reg_addr, reg_wdata, reg_be, ext_ack, ext_rdata,
    input  reg_ack, reg_rdata, reg_err, ext_req, ext_we, ext_addr, ext_wdata, ext_be
  );
endinterface

`default_nettype wire

// File: rtl/regfile_ext_slave.sv
// ============================================================================
// regfile_ext_slave : RW/RO/W1C register file with one forwarded external window
// Optional macro REGFILE_EXT_TIMEOUT_EN adds the external-access timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_ext_slave #(
  parameter int                     DATA_W      = 32,
  parameter int                     ADDR_W      = 12,
  parameter int                     NREG        = 16,
  parameter logic [ADDR_W-1:0]      EXT_BASE    = 12'h800,
  parameter int                     EXT_TIMEOUT = 64,
  parameter logic [NREG-1:0]        RO_MASK     = '0,
  parameter logic [NREG-1:0]        W1C_MASK    = '0,
  parameter logic [NREG*DATA_W-1:0] RESET_VAL   = '0
) (
  input  wire logic                     sysclk,
  input  wire logic                     sysrst_n,
  regfile_ext_slave_if.slave            bus,
  input  wire logic [NREG*DATA_W-1:0]   hw_rdata,
  input  wire logic [NREG*DATA_W-1:0]   hw_set,
  output logic      [NREG*DATA_W-1:0]   reg_q
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, INT, EXT_WAIT, RESP} state_t;

  state_t              state, state_nx;
  logic                we_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic [ADDR_W-1:0]   ext_addr_q;
  logic                ext_req_q, ext_req_nx;
  logic                ack_q, ack_nx;
  logic                err_q, err_nx;
  logic [DATA_W-1:0]   rdata_q, rdata_nx;
  logic                latch, ext_latch, int_wr;
  logic                idx_oob;
  logic [DATA_W-1:0]   rd_mux;
  logic [DATA_W-1:0]   bmask;
  logic                tmo_hit;

`ifdef REGFILE_EXT_TIMEOUT_EN
  localparam int TMO_W = $clog2(EXT_TIMEOUT);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n)              tmo_cnt <= '0;
    else if (state != EXT_WAIT) tmo_cnt <= '0;
    else                        tmo_cnt <= tmo_cnt + 1'b1;
  end
  assign tmo_hit = (tmo_cnt == TMO_W'(EXT_TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign idx_oob = (32'(idx_q) >= NREG);

  always_comb begin
    bmask = '0;
    for (int b = 0; b < BE_W; b++) bmask[b*8 +: 8] = {8{be_q[b]}};
    rd_mux = '0;
    for (int i = 0; i < NREG; i++)
      if (idx_q == IDX_W'(i)) rd_mux = reg_q[i*DATA_W +: DATA_W];
  end

  always_comb begin
    state_nx   = state;
    ext_req_nx = ext_req_q;
    ack_nx     = 1'b0;
    err_nx     = err_q;
    rdata_nx   = rdata_q;
    latch      = 1'b0;
    ext_latch  = 1'b0;
    int_wr     = 1'b0;
    case (state)
      IDLE: if (bus.reg_req) begin
        latch = 1'b1;
        if (bus.reg_addr < EXT_BASE) begin
          state_nx = INT;
        end else begin
          ext_latch  = 1'b1;
          ext_req_nx = 1'b1;
          state_nx   = EXT_WAIT;
        end
      end
      INT: begin
        ack_nx   = 1'b1;
        state_nx = RESP;
        if (idx_oob) begin
          err_nx   = 1'b1;
          rdata_nx = '0;
        end else begin
          err_nx   = 1'b0;
          rdata_nx = rd_mux;
          int_wr   = we_q;
        end
      end
      EXT_WAIT: begin
        // a genuine ack wins over a timeout expiring on the same edge
        if (bus.ext_ack) begin
          ext_req_nx = 1'b0;
          ack_nx     = 1'b1;
          err_nx     = 1'b0;
          rdata_nx   = bus.ext_rdata;
          state_nx   = RESP;
        end else if (tmo_hit) begin
          ext_req_nx = 1'b0;
          ack_nx     = 1'b1;
          err_nx     = 1'b1;
          rdata_nx   = '1;
          state_nx   = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      ext_addr_q <= '0;
      ext_req_q  <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state     <= state_nx;
      ext_req_q <= ext_req_nx;
      ack_q     <= ack_nx;
      err_q     <= err_nx;
      rdata_q   <= rdata_nx;
      if (latch) begin
        we_q    <= bus.reg_we;
        idx_q   <= bus.reg_addr[ADDR_W-1:2];
        wdata_q <= bus.reg_wdata;
        be_q    <= bus.reg_be;
      end
      if (ext_latch) ext_addr_q <= bus.reg_addr - EXT_BASE;
    end
  end

  assign bus.reg_ack   = ack_q;
  assign bus.reg_err   = err_q;
  assign bus.reg_rdata = rdata_q;
  assign bus.ext_req   = ext_req_q;
  assign bus.ext_we    = we_q;
  assign bus.ext_addr  = ext_addr_q;
  assign bus.ext_wdata = wdata_q;
  assign bus.ext_be    = be_q;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      logic unused_ro;
      assign unused_ro = ^hw_set[i*DATA_W +: DATA_W];
      assign reg_q[i*DATA_W +: DATA_W] = hw_rdata[i*DATA_W +: DATA_W];
    end else if (W1C_MASK[i]) begin : g_w1c
      logic [DATA_W-1:0] q;
      logic [DATA_W-1:0] clr;
      logic              unused_w1c;
      assign unused_w1c = ^hw_rdata[i*DATA_W +: DATA_W];
      assign clr = (int_wr && idx_q == IDX_W'(i)) ? (wdata_q & bmask) : '0;
      // set is OR-ed after the clear so a simultaneous hardware set wins
      always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) q <= RESET_VAL[i*DATA_W +: DATA_W];
        else           q <= (q & ~clr) | hw_set[i*DATA_W +: DATA_W];
      end
      assign reg_q[i*DATA_W +: DATA_W] = q;
    end else begin : g_rw
      logic [DATA_W-1:0] q;
      logic              unused_rw;
      assign unused_rw = ^{hw_rdata[i*DATA_W +: DATA_W], hw_set[i*DATA_W +: DATA_W]};
      always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n)                         q <= RESET_VAL[i*DATA_W +: DATA_W];
        else if (int_wr && idx_q == IDX_W'(i)) q <= (q & ~bmask) | (wdata_q & bmask);
      end
      assign reg_q[i*DATA_W +: DATA_W] = q;
    end
  end

endmodule

`default_nettype wire

// File: doc/regfile_ext_slave.md
# regfile_ext_slave

Parametrised register-file slave that implements the hardware side of the team's register model (register / field / section / external). It decodes a simple request/acknowledge register bus into NREG internal registers with per-register access type (RW, RO, W1C) and forwards one address window to an external section over a handshaked port. It sits between the host register bus bridge and a sub-block's control/status logic.

## Interface
- DATA_W, 32: register width, multiple of 8.
- ADDR_W, 12: byte address width.
- NREG, 16: internal register count, 1..(EXT_BASE/4).
- EXT_BASE, 12'h800: first byte address of external window; window spans EXT_BASE..2^ADDR_W-1.
- EXT_TIMEOUT, 64: external wait limit in cycles, >=2.
- RO_MASK, '0: NREG bits; bit i=1 makes register i RO, read from hw_rdata.
- W1C_MASK, '0: NREG bits; bit i=1 makes register i W1C (RO_MASK takes precedence).
- RESET_VAL, '0: NREG*DATA_W packed reset values, register i at [i*DATA_W +: DATA_W].

Ports:
- sysclk  in  1  sole clock.
- sysrst_n  in  1  asynchronous active-low reset.
- reg_req  in  1  access request, held until reg_ack.
- reg_we  in  1  1=write, 0=read.
- reg_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- reg_wdata  in  DATA_W  write data.
- reg_be  in  DATA_W/8  byte enables.
- reg_ack  out  1  one-cycle completion pulse.
- reg_rdata  out  DATA_W  read data, valid with reg_ack.
- reg_err  out  1  error flag, valid with reg_ack.
- ext_req / ext_we  out  1  external request, write.
- ext_addr  out  ADDR_W  offset from EXT_BASE.
- ext_wdata  out  DATA_W; ext_be  out  DATA_W/8.
- ext_ack  in  1  external completion; ext_rdata  in  DATA_W.
- hw_rdata  in  NREG*DATA_W  values for RO registers.
- hw_set  in  NREG*DATA_W  per-bit set pulses for W1C registers.
- reg_q  out  NREG*DATA_W  current register contents.

## Operation
- FSM: IDLE, INT, EXT_WAIT, RESP.
- IDLE: on reg_req, latch we/addr/wdata/be; addr < EXT_BASE -> INT; else -> EXT_WAIT with ext_req=1.
- INT: index = addr[ADDR_W-1:2]. index >= NREG -> reg_err=1, rdata 0. RW: write byte-wise under be. RO: write ignored, no error. W1C: write 1 clears bit (masked by be), write 0 no effect. Read returns reg_q (RO: hw_rdata). -> RESP.
- EXT_WAIT: ext_* stable while ext_req=1. On ext_ack: capture ext_rdata, drop ext_req, -> RESP. On timeout: drop ext_req, reg_err=1, rdata all ones, -> RESP.
- RESP: reg_ack=1 for one cycle -> IDLE. The master drops reg_req in the ack cycle; the next request is accepted no earlier than the following cycle.
- W1C bits: set every cycle where hw_set bit=1, regardless of FSM state. Simultaneous set and clear of the same bit -> set wins.
- ext_ack outside EXT_WAIT is ignored.
- Reset: FSM IDLE; reg_ack, reg_err, ext_req, ext_we = 0; reg_rdata, ext_addr, ext_wdata, ext_be = 0; registers = RESET_VAL. Reset mid-transaction aborts with no ack.

## Timing
- Internal access: reg_req sampled at edge N, reg_ack high in cycle N+2.
- External access: ext_req high from cycle N+1; ext_ack at edge M -> reg_ack in cycle M+1.
- Register update becomes visible on reg_q in the cycle after the INT state.
- Timeout: ext_req held for EXT_TIMEOUT cycles, then dropped, with reg_ack 1 cycle later.
- Throughput: at most one access per 3 cycles.

## Configuration
- REGFILE_EXT_TIMEOUT_EN defined: timeout counter present; behaviour as above.
- Not defined: no counter; EXT_WAIT waits indefinitely for ext_ack, and reg_err is only raised by internal decode errors.

## Test plan
- Reset with RESET_VAL reg0=32'h1234_5678 -> reg_q[31:0]=32'h1234_5678; all bus outputs 0.
- RW reg1 write 32'hAABB_CCDD, be=4'b0101 -> read returns 32'h00BB_00DD; ack 2 cycles after req.
- W1C reg2: hw_set bit3 -> read 32'h8; write 32'h8 while hw_set bit3 is still high -> bit stays 1; write 32'h8 with hw_set low -> reads 0.
- Read addr 12'h7FC with NREG=16 -> reg_err=1, rdata=0.
- External read at 12'h810, ext_ack after 5 cycles with ext_rdata=32'hCAFE_F00D -> ext_addr=12'h010, reg_rdata=32'hCAFE_F00D, err=0.
- With REGFILE_EXT_TIMEOUT_EN and no ext_ack -> ext_req high for 64 cycles, then reg_ack with reg_err=1 and rdata=32'hFFFF_FFFF.
